// File: rtl/clint_ctrl.sv
// ============================================================================
// Module   : clint_ctrl
// Purpose  : Core-local trap sequencer - ecall/ebreak/mret/external irq at EX,
//            sequential CSR updates through the clint write port, then redirect.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef RV32_ADDR_WIDTH
`define RV32_ADDR_WIDTH 32
`endif
`ifndef RV32_DATA_WIDTH
`define RV32_DATA_WIDTH 32
`endif
`ifndef CSR_ADDR_MSTATUS
`define CSR_ADDR_MSTATUS 12'h300
`endif
`ifndef CSR_ADDR_MTVEC
`define CSR_ADDR_MTVEC 12'h305
`endif
`ifndef CSR_ADDR_MEPC
`define CSR_ADDR_MEPC 12'h341
`endif
`ifndef CSR_ADDR_MCAUSE
`define CSR_ADDR_MCAUSE 12'h342
`endif

module clint_ctrl (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_inst_valid,
  input  logic [`RV32_ADDR_WIDTH-1:0] i_inst_pc,
  input  logic                        i_ecall,
  input  logic                        i_ebreak,
  input  logic                        i_mret,
  input  logic                        i_ext_irq,
  input  logic [`RV32_DATA_WIDTH-1:0] i_csr_mstatus,
  input  logic [`RV32_DATA_WIDTH-1:0] i_csr_mepc,
  input  logic [`RV32_DATA_WIDTH-1:0] i_csr_mtvec,
  output logic                        o_clint_mode,
  output logic                        o_clint_csr_wr_en,
  output logic [`RV32_ADDR_WIDTH-1:0] o_clint_csr_wr_addr,
  output logic [`RV32_DATA_WIDTH-1:0] o_clint_csr_wr_data,
  output logic                        o_hold,
  output logic                        o_jump_en,
  output logic [`RV32_ADDR_WIDTH-1:0] o_jump_addr
);

  localparam int AW = `RV32_ADDR_WIDTH;
  localparam int DW = `RV32_DATA_WIDTH;

  localparam logic [AW-1:0] ADDR_MSTATUS = {{(AW-12){1'b0}}, `CSR_ADDR_MSTATUS};
  localparam logic [AW-1:0] ADDR_MEPC    = {{(AW-12){1'b0}}, `CSR_ADDR_MEPC};
  localparam logic [AW-1:0] ADDR_MCAUSE  = {{(AW-12){1'b0}}, `CSR_ADDR_MCAUSE};

  localparam logic [DW-1:0] CAUSE_ECALL  = DW'(11);
  localparam logic [DW-1:0] CAUSE_EBREAK = DW'(3);
  localparam logic [DW-1:0] CAUSE_IRQ    = {1'b1, {(DW-5){1'b0}}, 4'hB};

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_T_MEPC    = 3'd1;
  localparam logic [2:0] S_T_MCAUSE  = 3'd2;
  localparam logic [2:0] S_T_MSTATUS = 3'd3;
  localparam logic [2:0] S_T_JUMP    = 3'd4;
  localparam logic [2:0] S_R_MSTATUS = 3'd5;
  localparam logic [2:0] S_R_JUMP    = 3'd6;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [AW-1:0] pc_q;
  logic [DW-1:0] cause_q;

  logic ev_ecall;
  logic ev_ebreak;
  logic ev_mret;
  logic ev_irq;
  logic take_trap;
  logic accept;
  logic unused_bits;

  assign ev_ecall  = i_inst_valid & i_ecall;
  assign ev_ebreak = i_inst_valid & i_ebreak;
  assign ev_mret   = i_inst_valid & i_mret;
  assign ev_irq    = i_inst_valid & i_ext_irq & i_csr_mstatus[3];

  // mret outranks the interrupt, but not ecall/ebreak
  assign take_trap = ev_ecall | ev_ebreak | (~ev_mret & ev_irq);
  // gated by rst so every output is 0 for the whole reset period
  assign accept    = ~rst & (state == S_IDLE) & (take_trap | ev_mret);

  assign unused_bits = ^i_csr_mtvec[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        pc_q <= i_inst_pc;
        if (take_trap) begin
          cause_q <= ev_ecall ? CAUSE_ECALL : (ev_ebreak ? CAUSE_EBREAK : CAUSE_IRQ);
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (accept) state_nxt = take_trap ? S_T_MEPC : S_R_MSTATUS;
      S_T_MEPC:    state_nxt = S_T_MCAUSE;
      S_T_MCAUSE:  state_nxt = S_T_MSTATUS;
      S_T_MSTATUS: state_nxt = S_T_JUMP;
      S_T_JUMP:    state_nxt = S_IDLE;
      S_R_MSTATUS: state_nxt = S_R_JUMP;
      S_R_JUMP:    state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_clint_mode        = 1'b0;
    o_clint_csr_wr_en   = 1'b0;
    o_clint_csr_wr_addr = '0;
    o_clint_csr_wr_data = '0;
    o_jump_en           = 1'b0;
    o_jump_addr         = '0;
    o_hold              = (state != S_IDLE) | accept;
    case (state)
      S_T_MEPC: begin
        o_clint_mode        = 1'b1;
        o_clint_csr_wr_en   = 1'b1;
        o_clint_csr_wr_addr = ADDR_MEPC;
        o_clint_csr_wr_data = pc_q;
      end
      S_T_MCAUSE: begin
        o_clint_mode        = 1'b1;
        o_clint_csr_wr_en   = 1'b1;
        o_clint_csr_wr_addr = ADDR_MCAUSE;
        o_clint_csr_wr_data = cause_q;
      end
      S_T_MSTATUS: begin
        o_clint_mode           = 1'b1;
        o_clint_csr_wr_en      = 1'b1;
        o_clint_csr_wr_addr    = ADDR_MSTATUS;
        o_clint_csr_wr_data    = i_csr_mstatus;
        o_clint_csr_wr_data[7] = i_csr_mstatus[3];
        o_clint_csr_wr_data[3] = 1'b0;
      end
      S_T_JUMP: begin
        o_jump_en   = 1'b1;
        o_jump_addr = {i_csr_mtvec[AW-1:2], 2'b00};
      end
      S_R_MSTATUS: begin
        o_clint_mode           = 1'b1;
        o_clint_csr_wr_en      = 1'b1;
        o_clint_csr_wr_addr    = ADDR_MSTATUS;
        o_clint_csr_wr_data    = i_csr_mstatus;
        o_clint_csr_wr_data[3] = i_csr_mstatus[7];
        o_clint_csr_wr_data[7] = 1'b1;
      end
      S_R_JUMP: begin
        o_jump_en   = 1'b1;
        o_jump_addr = i_csr_mepc;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_clint_ctrl.sv
// ============================================================================
// Module   : tb_clint_ctrl
// Purpose  : Directed bench for clint_ctrl with an operation-queue model and
//            a small CSR file driven by the DUT write port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_clint_ctrl;

  localparam int OP_W_MEPC    = 1;
  localparam int OP_W_MCAUSE  = 2;
  localparam int OP_W_MS_TRAP = 3;
  localparam int OP_JUMP_VEC  = 4;
  localparam int OP_W_MS_RET  = 5;
  localparam int OP_JUMP_EPC  = 6;

  localparam int P_JADDR   = 0;
  localparam int P_JEN     = 1;
  localparam int P_HOLD    = 2;
  localparam int P_MEPC    = 3;
  localparam int P_MCAUSE  = 4;
  localparam int P_MSTATUS = 5;
  localparam int P_WREN    = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_valid = 1'b0;
  logic [31:0] inst_pc = '0;
  logic        ecall = 1'b0;
  logic        ebreak = 1'b0;
  logic        mret = 1'b0;
  logic        ext_irq = 1'b0;

  logic [31:0] mstatus_r = '0;
  logic [31:0] mepc_r = '0;
  logic [31:0] mtvec_r = '0;
  logic [31:0] mcause_r = '0;

  logic        preset_en = 1'b0;
  logic [31:0] p_mstatus = '0;
  logic [31:0] p_mepc = '0;
  logic [31:0] p_mtvec = '0;
  logic [31:0] p_mcause = '0;

  logic        clint_mode;
  logic        csr_wr_en;
  logic [31:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic        hold;
  logic        jump_en;
  logic [31:0] jump_addr;

  logic        pin_en = 1'b0;
  int          pin_id = 0;
  logic [31:0] pin_exp = '0;

  int n_checks = 0;
  int n_fail = 0;

  clint_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_inst_valid        (inst_valid),
    .i_inst_pc           (inst_pc),
    .i_ecall             (ecall),
    .i_ebreak            (ebreak),
    .i_mret              (mret),
    .i_ext_irq           (ext_irq),
    .i_csr_mstatus       (mstatus_r),
    .i_csr_mepc          (mepc_r),
    .i_csr_mtvec         (mtvec_r),
    .o_clint_mode        (clint_mode),
    .o_clint_csr_wr_en   (csr_wr_en),
    .o_clint_csr_wr_addr (csr_wr_addr),
    .o_clint_csr_wr_data (csr_wr_data),
    .o_hold              (hold),
    .o_jump_en           (jump_en),
    .o_jump_addr         (jump_addr)
  );

  always #5 clk = ~clk;

  // CSR file: the DUT's write port lands here; presets load directly
  always @(posedge clk) begin
    if (preset_en) begin
      mstatus_r <= p_mstatus;
      mepc_r    <= p_mepc;
      mtvec_r   <= p_mtvec;
      mcause_r  <= p_mcause;
    end else if (csr_wr_en) begin
      case (csr_wr_addr)
        32'h300: mstatus_r <= csr_wr_data;
        32'h305: mtvec_r   <= csr_wr_data;
        32'h341: mepc_r    <= csr_wr_data;
        32'h342: mcause_r  <= csr_wr_data;
        default: ;
      endcase
    end
  end

  function automatic string pin_name(input int id);
    case (id)
      P_JADDR:   return "jump_addr";
      P_JEN:     return "jump_en";
      P_HOLD:    return "hold";
      P_MEPC:    return "csr_mepc";
      P_MCAUSE:  return "csr_mcause";
      P_MSTATUS: return "csr_mstatus";
      default:   return "csr_wr_en";
    endcase
  endfunction

  // Model: an accepted event schedules a list of operations, one per cycle
  initial begin
    int          opq[$];
    int          op;
    logic [31:0] m_pc;
    logic [31:0] m_cause;
    logic        e_mode, e_wr, e_hold, e_jen;
    logic [31:0] e_addr, e_data, e_jaddr, pv;
    logic [99:0] exp_v, act_v;
    m_pc = '0;
    m_cause = '0;
    forever begin
      @(negedge clk);
      e_mode = 1'b0; e_wr = 1'b0; e_hold = 1'b0; e_jen = 1'b0;
      e_addr = '0; e_data = '0; e_jaddr = '0;
      if (rst) begin
        opq.delete();
      end else if (opq.size() != 0) begin
        op = opq.pop_front();
        e_hold = 1'b1;
        case (op)
          OP_W_MEPC:    begin e_mode = 1'b1; e_wr = 1'b1; e_addr = 32'h341; e_data = m_pc; end
          OP_W_MCAUSE:  begin e_mode = 1'b1; e_wr = 1'b1; e_addr = 32'h342; e_data = m_cause; end
          OP_W_MS_TRAP: begin
            e_mode = 1'b1; e_wr = 1'b1; e_addr = 32'h300;
            e_data = (mstatus_r & ~32'h88) | (mstatus_r[3] ? 32'h80 : 32'h0);
          end
          OP_W_MS_RET:  begin
            e_mode = 1'b1; e_wr = 1'b1; e_addr = 32'h300;
            e_data = (mstatus_r & ~32'h8) | (mstatus_r[7] ? 32'h8 : 32'h0) | 32'h80;
          end
          OP_JUMP_VEC:  begin e_jen = 1'b1; e_jaddr = mtvec_r & ~32'h3; end
          default:      begin e_jen = 1'b1; e_jaddr = mepc_r; end
        endcase
      end else if (inst_valid) begin
        if (ecall || ebreak || (!mret && ext_irq && mstatus_r[3])) begin
          m_pc    = inst_pc;
          m_cause = ecall ? 32'd11 : (ebreak ? 32'd3 : 32'h8000_000B);
          opq     = '{OP_W_MEPC, OP_W_MCAUSE, OP_W_MS_TRAP, OP_JUMP_VEC};
          e_hold  = 1'b1;
        end else if (mret) begin
          opq    = '{OP_W_MS_RET, OP_JUMP_EPC};
          e_hold = 1'b1;
        end
      end
      exp_v = {e_mode, e_wr, e_addr, e_data, e_hold, e_jen, e_jaddr};
      act_v = {clint_mode, csr_wr_en, csr_wr_addr, csr_wr_data, hold, jump_en, jump_addr};
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL outputs @%0t: got %h expected %h (mode,wr,addr,data,hold,jen,jaddr)",
                 $time, act_v, exp_v);
      end
      if (pin_en) begin
        case (pin_id)
          P_JADDR:   pv = jump_addr;
          P_JEN:     pv = {31'd0, jump_en};
          P_HOLD:    pv = {31'd0, hold};
          P_MEPC:    pv = mepc_r;
          P_MCAUSE:  pv = mcause_r;
          P_MSTATUS: pv = mstatus_r;
          default:   pv = {31'd0, csr_wr_en};
        endcase
        n_checks++;
        if (pv !== pin_exp) begin
          n_fail++;
          $display("FAIL %s @%0t: got %h expected %h", pin_name(pin_id), $time, pv, pin_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    pin_en = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pin(input int id, input logic [31:0] expv);
    pin_id  = id;
    pin_exp = expv;
    pin_en  = 1'b1;
  endtask

  task automatic preset(input logic [31:0] ms, input logic [31:0] epc,
                        input logic [31:0] tvec, input logic [31:0] cause);
    p_mstatus = ms; p_mepc = epc; p_mtvec = tvec; p_mcause = cause;
    preset_en = 1'b1;
    tick();
    preset_en = 1'b0;
  endtask

  initial begin
    // reset with a pending ecall: outputs must stay 0
    inst_valid = 1'b1; ecall = 1'b1;
    pin(P_HOLD, 0); tick();
    pin(P_HOLD, 0); tick();
    rst = 1'b0; inst_valid = 1'b0; ecall = 1'b0;

    // ecall
    preset(32'h8, 32'h0, 32'h100, 32'h0);
    inst_pc = 32'h40; inst_valid = 1'b1; ecall = 1'b1;
    pin(P_HOLD, 1); tick();
    pin(P_WREN, 1); tick();
    run(2);
    pin(P_JADDR, 32'h100); tick();
    inst_valid = 1'b0; ecall = 1'b0;
    pin(P_MEPC, 32'h40); tick();
    pin(P_MCAUSE, 32'd11); tick();
    pin(P_MSTATUS, 32'h80); tick();
    pin(P_HOLD, 0); tick();

    // ecall + ebreak + irq together, then irq pending with MIE=0
    preset(32'h8, 32'h0, 32'h100, 32'h0);
    inst_pc = 32'h80; inst_valid = 1'b1; ecall = 1'b1; ebreak = 1'b1; ext_irq = 1'b1;
    run(5);
    inst_valid = 1'b0; ecall = 1'b0; ebreak = 1'b0;
    pin(P_MCAUSE, 32'd11); tick();
    inst_pc = 32'h84; inst_valid = 1'b1;
    pin(P_HOLD, 0); tick();
    pin(P_HOLD, 0); tick();
    pin(P_MSTATUS, 32'h80); tick();
    inst_valid = 1'b0; ext_irq = 1'b0;

    // mret
    preset(32'h80, 32'h44, 32'h100, 32'h0);
    inst_pc = 32'h90; inst_valid = 1'b1; mret = 1'b1;
    pin(P_HOLD, 1); tick();
    pin(P_WREN, 1); tick();
    pin(P_JADDR, 32'h44); tick();
    inst_valid = 1'b0; mret = 1'b0;
    pin(P_MSTATUS, 32'h88); tick();

    // interrupt taken, mtvec low bits masked; then ignored once MIE=0
    preset(32'h8, 32'h0, 32'h107, 32'h0);
    inst_pc = 32'h200; inst_valid = 1'b1; ext_irq = 1'b1;
    pin(P_HOLD, 1); tick();
    run(3);
    pin(P_JADDR, 32'h104); tick();
    inst_valid = 1'b0;
    pin(P_MEPC, 32'h200); tick();
    pin(P_MCAUSE, 32'h8000_000B); tick();
    inst_pc = 32'h204; inst_valid = 1'b1;
    pin(P_HOLD, 0); tick();
    pin(P_MSTATUS, 32'h80); tick();
    inst_valid = 1'b0; ext_irq = 1'b0;

    // interrupt waits for a valid EX instruction
    preset(32'h8, 32'h0, 32'h100, 32'h0);
    ext_irq = 1'b1;
    pin(P_HOLD, 0); tick();
    run(2);
    inst_pc = 32'h300; inst_valid = 1'b1;
    pin(P_HOLD, 1); tick();
    run(4);
    inst_valid = 1'b0; ext_irq = 1'b0;
    pin(P_MCAUSE, 32'h8000_000B); tick();
    pin(P_MEPC, 32'h300); tick();

    // reset during the mcause write
    preset(32'h8, 32'h0, 32'h100, 32'h55);
    inst_pc = 32'h400; inst_valid = 1'b1; ecall = 1'b1;
    run(2);
    rst = 1'b1;
    pin(P_WREN, 0); tick();
    pin(P_JEN, 0); tick();
    rst = 1'b0; inst_valid = 1'b0; ecall = 1'b0;
    pin(P_MCAUSE, 32'h55); tick();
    pin(P_MEPC, 32'h400); tick();
    pin(P_MSTATUS, 32'h8); tick();
    inst_pc = 32'h404; inst_valid = 1'b1; ecall = 1'b1;
    run(5);
    inst_valid = 1'b0; ecall = 1'b0;
    pin(P_MCAUSE, 32'd11); tick();
    pin(P_MEPC, 32'h404); tick();
    pin(P_MSTATUS, 32'h80); tick();

    // back-to-back: new accept right after the jump
    preset(32'h8, 32'h0, 32'h100, 32'h0);
    inst_pc = 32'h500; inst_valid = 1'b1; ecall = 1'b1;
    run(5);
    inst_pc = 32'h504; ecall = 1'b0; ebreak = 1'b1;
    pin(P_HOLD, 1); tick();
    run(4);
    inst_valid = 1'b0; ebreak = 1'b0;
    pin(P_MCAUSE, 32'd3); tick();
    pin(P_MEPC, 32'h504); tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
